// File: rtl/obs_pkg.sv
// ============================================================================
// Module : obs_pkg
// Brief  : Shared FSM encoding, default sizes and cfg field layout for the
//          observation scan sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package obs_pkg;

  localparam int N_CH_DEF   = 4;
  localparam int ROT_W_DEF  = 10;

  localparam int CFG_W      = 8;
  localparam int MASK_LSB   = 0;
  localparam int SETTLE_LSB = 4;
  localparam int SETTLE_W   = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    ACQ    = 3'd2,
    ROTATE = 3'd3,
    DONE   = 3'd4
  } state_e;

endpackage

`default_nettype wire

// File: rtl/obs_ch_sel.sv
// ============================================================================
// Module : obs_ch_sel
// Brief  : Combinational finder for the lowest enabled channel and the next
//          enabled channel above the current one-hot selection.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module obs_ch_sel #(
  parameter int N_CH = 4
) (
  input  logic [N_CH-1:0] mask_i,
  input  logic [N_CH-1:0] cur_i,
  output logic [N_CH-1:0] first_o,
  output logic [N_CH-1:0] next_o,
  output logic            last_o
);

  always_comb begin
    logic found_first;
    logic found_next;
    logic above_cur;
    first_o     = '0;
    next_o      = '0;
    found_first = 1'b0;
    found_next  = 1'b0;
    above_cur   = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (mask_i[i] && !found_first) begin
        first_o[i]  = 1'b1;
        found_first = 1'b1;
      end
      // Only bits strictly above the current selection qualify as "next".
      if (mask_i[i] && above_cur && !found_next) begin
        next_o[i]  = 1'b1;
        found_next = 1'b1;
      end
      if (cur_i[i]) begin
        above_cur = 1'b1;
      end
    end
    last_o = !found_next;
  end

endmodule

`default_nettype wire

// File: rtl/obs_scan_sched.sv
// ============================================================================
// Module : obs_scan_sched
// Brief  : Observation scan sequencer: per rotator step, cycles the RF switch
//          through enabled channels with settle dwell and ADC handshake.
//          Optional ACQ timeout enabled by defining OBS_ACQ_TIMEOUT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module obs_scan_sched
  import obs_pkg::*;
#(
  parameter int N_CH      = N_CH_DEF,
  parameter int ROT_W     = ROT_W_DEF,
  parameter int ROT_STEPS = 360,
  parameter int TIMEOUT   = 1023
) (
  input  logic             stp_clk,
  input  logic             sys_init_ctrl_n,
  input  logic             trg_ctrl,
  input  logic [CFG_W-1:0] sw,
  input  logic             adc_done,
  output logic             rot_en,
  output logic             wrk_stat,
  output logic             adc_en,
  output logic [N_CH-1:0]  rf_sw,
  output logic [ROT_W-1:0] rot_count,
  output logic             scan_done,
  output logic             acq_err
);

  localparam logic [ROT_W-1:0] LAST_STEP = ROT_W'(ROT_STEPS - 1);

  state_e              state_q, state_d;
  logic [CFG_W-1:0]    cfg_q, cfg_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [N_CH-1:0]     rf_sw_q, rf_sw_d;
  logic [ROT_W-1:0]    rot_count_q, rot_count_d;
  logic                rot_en_q, adc_en_q, wrk_stat_q, scan_done_q;
  logic                acq_end;

  logic [N_CH-1:0]     sw_mask, sel_mask, first_ch, next_ch;
  logic                last_ch;

`ifdef OBS_ACQ_TIMEOUT_EN
  localparam int              TMO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             acq_err_q, acq_err_d;
`endif

  assign sw_mask = sw[MASK_LSB +: N_CH];
  // In IDLE cfg is not latched yet, so the first channel comes straight from sw.
  assign sel_mask = (state_q == IDLE) ? sw_mask : cfg_q[MASK_LSB +: N_CH];

  obs_ch_sel #(
    .N_CH (N_CH)
  ) u_ch_sel (
    .mask_i  (sel_mask),
    .cur_i   (rf_sw_q),
    .first_o (first_ch),
    .next_o  (next_ch),
    .last_o  (last_ch)
  );

  always_comb begin
    state_d     = state_q;
    cfg_d       = cfg_q;
    settle_d    = settle_q;
    rf_sw_d     = rf_sw_q;
    rot_count_d = rot_count_q;
    acq_end     = 1'b0;
`ifdef OBS_ACQ_TIMEOUT_EN
    tmo_d       = tmo_q;
    acq_err_d   = acq_err_q;
`endif

    case (state_q)
      IDLE: begin
        if (trg_ctrl && (sw_mask != '0)) begin
          cfg_d       = sw;
          rot_count_d = '0;
          rf_sw_d     = first_ch;
          settle_d    = sw[SETTLE_LSB +: SETTLE_W];
          state_d     = SETTLE;
`ifdef OBS_ACQ_TIMEOUT_EN
          acq_err_d   = 1'b0;
`endif
        end
      end

      SETTLE: begin
        if (settle_q == '0) begin
          state_d = ACQ;
`ifdef OBS_ACQ_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end else begin
          settle_d = settle_q - 1'b1;
        end
      end

      ACQ: begin
        acq_end = adc_done;
`ifdef OBS_ACQ_TIMEOUT_EN
        tmo_d = tmo_q + 1'b1;
        // A done arriving on the expiry cycle wins; the error is only for a true miss.
        if (!adc_done && (tmo_q == TMO_LAST)) begin
          acq_end   = 1'b1;
          acq_err_d = 1'b1;
        end
`endif
        if (acq_end) begin
          if (!last_ch) begin
            rf_sw_d  = next_ch;
            settle_d = cfg_q[SETTLE_LSB +: SETTLE_W];
            state_d  = SETTLE;
          end else begin
            state_d  = ROTATE;
          end
        end
      end

      ROTATE: begin
        if (rot_count_q == LAST_STEP) begin
          rot_count_d = '0;
          rf_sw_d     = '0;
          state_d     = DONE;
        end else begin
          rot_count_d = rot_count_q + 1'b1;
          rf_sw_d     = first_ch;
          settle_d    = cfg_q[SETTLE_LSB +: SETTLE_W];
          state_d     = SETTLE;
        end
      end

      DONE: begin
        rf_sw_d = '0;
        state_d = IDLE;
      end

      default: begin
        rf_sw_d = '0;
        state_d = IDLE;
      end
    endcase

    // Abort overrides every transition above, including done and timer expiry.
    if ((state_q != IDLE) && !trg_ctrl) begin
      state_d     = IDLE;
      rf_sw_d     = '0;
      rot_count_d = rot_count_q;
      settle_d    = settle_q;
`ifdef OBS_ACQ_TIMEOUT_EN
      acq_err_d   = acq_err_q;
`endif
    end
  end

  always_ff @(posedge stp_clk or negedge sys_init_ctrl_n) begin
    if (!sys_init_ctrl_n) begin
      state_q     <= IDLE;
      cfg_q       <= '0;
      settle_q    <= '0;
      rf_sw_q     <= '0;
      rot_count_q <= '0;
      rot_en_q    <= 1'b0;
      adc_en_q    <= 1'b0;
      wrk_stat_q  <= 1'b0;
      scan_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cfg_q       <= cfg_d;
      settle_q    <= settle_d;
      rf_sw_q     <= rf_sw_d;
      rot_count_q <= rot_count_d;
      rot_en_q    <= (state_d == ROTATE);
      adc_en_q    <= (state_d == ACQ);
      wrk_stat_q  <= (state_d != IDLE);
      scan_done_q <= (state_d == DONE);
    end
  end

`ifdef OBS_ACQ_TIMEOUT_EN
  always_ff @(posedge stp_clk or negedge sys_init_ctrl_n) begin
    if (!sys_init_ctrl_n) begin
      tmo_q     <= '0;
      acq_err_q <= 1'b0;
    end else begin
      tmo_q     <= tmo_d;
      acq_err_q <= acq_err_d;
    end
  end

  assign acq_err = acq_err_q;
`else
  assign acq_err = 1'b0;
`endif

  assign rot_en    = rot_en_q;
  assign wrk_stat  = wrk_stat_q;
  assign adc_en    = adc_en_q;
  assign rf_sw     = rf_sw_q;
  assign rot_count = rot_count_q;
  assign scan_done = scan_done_q;

endmodule

`default_nettype wire
